ps2_tx: RTL and testbench

//  PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_clk_filter.sv | 30 +++
 rtl/ps2_tx.sv | 111 +++++++++++
 tb/tb_ps2_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 transmitter state encoding, keyboard command bytes and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_REQ,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: 8-sample glitch filter on the PS/2 clock with a falling-edge strobe.
module ps2_clk_filter (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    output logic f_val,
    output logic neg_edge
);

    logic [7:0] fil, fil_next;
    logic       f_next;

    // Reset to the idle-high bus level so reset release never fakes a falling edge.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            fil   <= '1;
            f_val <= 1'b1;
        end else begin
            fil   <= fil_next;
            f_val <= f_next;
        end

    always_comb begin
        fil_next = {ps2c, fil[7:1]};
        f_next   = &fil_next ? 1'b1 : ~|fil_next ? 1'b0 : f_val;
    end

    assign neg_edge = f_val & ~f_next;

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter (request-to-send, odd-parity framing, ack check).
// Define PS2_TX_TIMEOUT_EN to add a watchdog on the gap between device clock edges.
module ps2_tx
    import ps2_pkg::*;
#(
`ifdef PS2_TX_TIMEOUT_EN
    parameter int TIMEOUT_MS  = 15,
`endif
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int RW          = $clog2(INHIBIT_CYC + 1);

    state_t        state, state_next;
    logic [9:0]    sh;
    logic [3:0]    n;
    logic [RW-1:0] rts_cnt;
    logic [1:0]    d_sync;
    logic          f_val, neg_edge, timeout;

    ps2_clk_filter u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2c     (ps2c_in),
        .f_val    (f_val),
        .neg_edge (neg_edge)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
    localparam int WW          = $clog2(TIMEOUT_CYC + 1);

    logic [WW-1:0] wdt;
    logic          watched;

    assign watched = state == ST_DATA || state == ST_ACK || state == ST_WAIT_IDLE;
    assign timeout = watched && wdt == WW'(TIMEOUT_CYC - 1);

    // ST_REQ always leads into ST_DATA, so clearing there covers ST_DATA entry.
    always_ff @(posedge clk or posedge reset)
        if (reset) wdt <= '0;
        else if (state == ST_REQ || neg_edge) wdt <= '0;
        else if (watched) wdt <= wdt + 1'b1;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        if (timeout) state_next = ST_IDLE;
        else
            case (state)
                ST_IDLE:      state_next = tx_start ? ST_RTS : ST_IDLE;
                ST_RTS:       state_next = rts_cnt == RW'(INHIBIT_CYC - 1) ? ST_REQ : ST_RTS;
                ST_REQ:       state_next = ST_DATA;
                ST_DATA:      state_next = neg_edge && n == 4'd9 ? ST_ACK : ST_DATA;
                ST_ACK:       state_next = !neg_edge ? ST_ACK : d_sync[1] ? ST_IDLE : ST_WAIT_IDLE;
                ST_WAIT_IDLE: state_next = f_val && d_sync[1] ? ST_IDLE : ST_WAIT_IDLE;
                default:      state_next = ST_IDLE;
            endcase
    end

    // The start bit stays on the line until the first falling edge; each later edge shifts in the next bit.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            d_sync  <= 2'b11;
            sh      <= '1;
            n       <= '0;
            rts_cnt <= '0;
        end else begin
            d_sync <= {d_sync[0], ps2d_in};
            if (state == ST_IDLE && tx_start) begin
                sh      <= {1'b1, odd_parity(tx_data), tx_data};
                n       <= '0;
                rts_cnt <= '0;
            end else begin
                if (state == ST_RTS) rts_cnt <= rts_cnt + 1'b1;
                if (state == ST_DATA && neg_edge) begin
                    n <= n + 1'b1;
                    if (n != 4'd0) sh <= {1'b1, sh[9:1]};
                end
            end
        end

    always_comb begin
        ps2c_oe      = state == ST_RTS || state == ST_REQ;
        ps2d_oe      = state == ST_REQ || (state == ST_DATA && (n == 4'd0 || !sh[0]));
        tx_done_tick = state == ST_WAIT_IDLE && f_val && d_sync[1] && !timeout;
        tx_err_tick  = timeout || (state == ST_ACK && neg_edge && d_sync[1]);
        tx_busy      = state != ST_IDLE && !tx_done_tick;
    end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed and random frames against a behavioural PS/2 device model.
// Define PS2_TX_TIMEOUT_EN to also exercise the stalled-device watchdog.
module tb_ps2_tx;

    localparam int INHIBIT_CYC = 50_000_000 / 1_000_000 * 20;
`ifdef PS2_TX_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 50_000_000 / 1000 * 1;
`endif
    localparam int HALF = 40;

    logic       clk = 1'b0, reset = 1'b1, tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_c = 1'b1, dev_d = 1'b1;
    logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err_tick;
    int         vectors = 0, miscompares = 0, done_cnt = 0, err_cnt = 0, overlap = 0;

    // Open-drain bus: either side can pull a line low.
    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    always #5 clk = ~clk;

    ps2_tx #(
`ifdef PS2_TX_TIMEOUT_EN
        .TIMEOUT_MS  (1),
`endif
        .CLK_FREQ_HZ (50_000_000),
        .INHIBIT_US  (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .ps2c_in      (ps2c_in),
        .ps2d_in      (ps2d_in),
        .ps2c_oe      (ps2c_oe),
        .ps2d_oe      (ps2d_oe),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx_err_tick  (tx_err_tick)
    );

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt <= done_cnt + 1;
        if (tx_err_tick) err_cnt <= err_cnt + 1;
        if (tx_done_tick && tx_busy) overlap <= overlap + 1;
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bits as the device sees them: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(d[k]);
        return {1'b1, ones % 2 == 0, d, 1'b0};
    endfunction

    // mode: 0 ack, 1 no ack, 2 tx_start repeated mid-frame, 3 reset at bit 4, 4 device stalls after bit 3
    task automatic run_frame(input logic [7:0] d, input int mode);
        logic [10:0] got;
        int t, d0, e0;
        got = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data = d;
        tx_start = 1'b1;
        cyc(1);
        tx_start = 1'b0;
        tx_data = 8'($urandom);
        chk("busy_on_accept", tx_busy, 1);
        t = 0;
        while (ps2c_oe && !ps2d_oe && t < INHIBIT_CYC + 10) begin
            t++;
            cyc(1);
        end
        chk("rts_cycles", t, INHIBIT_CYC);
        chk("req_c", ps2c_oe, 1);
        chk("req_d", ps2d_oe, 1);
        cyc(1);
        chk("start_c_released", ps2c_oe, 0);
        chk("start_d_held", ps2d_oe, 1);
        cyc(HALF);
        got[0] = ps2d_in;
        for (int i = 1; i <= 10; i++) begin
            dev_c = 1'b0;
            if (mode == 3 && i == 4) begin
                cyc(HALF / 2);
                chk("pre_reset_d", ps2d_oe, 1);
                #2 reset = 1'b1;
                #1;
                chk("reset_c", ps2c_oe, 0);
                chk("reset_d", ps2d_oe, 0);
                chk("reset_busy", tx_busy, 0);
                dev_c = 1'b1;
                cyc(4);
                reset = 1'b0;
                cyc(20);
                chk("reset_no_tick", done_cnt - d0 + err_cnt - e0, 0);
                return;
            end
`ifdef PS2_TX_TIMEOUT_EN
            if (mode == 4 && i == 4) begin
                t = 0;
                while (!tx_err_tick && t < TIMEOUT_CYC + 100) begin
                    cyc(1);
                    t++;
                    if (t == HALF) dev_c = 1'b1;
                end
                // neg_edge is seen on the 8th low sample, the watchdog fires TIMEOUT_CYC cycles later
                chk("timeout_latency", t, TIMEOUT_CYC + 7);
                cyc(1);
                chk("timeout_c", ps2c_oe, 0);
                chk("timeout_d", ps2d_oe, 0);
                chk("timeout_busy", tx_busy, 0);
                chk("timeout_no_done", done_cnt - d0, 0);
                cyc(20);
                return;
            end
`endif
            if (mode == 2 && i == 4) begin
                tx_start = 1'b1;
                tx_data = 8'hFF;
                cyc(1);
                tx_start = 1'b0;
                cyc(HALF - 1);
            end else cyc(HALF);
            dev_c = 1'b1;
            got[i] = ps2d_in;
            cyc(HALF);
        end
        chk("frame_bits", got, frame_of(d));
        chk("ack_d_released", ps2d_oe, 0);
        if (mode != 1) dev_d = 1'b0;
        cyc(4);
        dev_c = 1'b0;
        cyc(HALF);
        dev_c = 1'b1;
        cyc(HALF / 2);
        dev_d = 1'b1;
        t = 0;
        while (tx_busy && t < 200) begin
            cyc(1);
            t++;
        end
        chk("busy_falls", tx_busy, 0);
        cyc(2);
        chk("done_pulses", done_cnt - d0, mode == 1 ? 0 : 1);
        chk("err_pulses", err_cnt - e0, mode == 1 ? 1 : 0);
        chk("idle_c", ps2c_oe, 0);
        chk("idle_d", ps2d_oe, 0);
        cyc(20);
    endtask

    initial begin
        cyc(3);
        chk("rst_c", ps2c_oe, 0);
        chk("rst_d", ps2d_oe, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done_tick, 0);
        chk("rst_err", tx_err_tick, 0);
        reset = 1'b0;
        cyc(20);
        chk("idle_no_ticks", done_cnt + err_cnt, 0);
        run_frame(8'hED, 0);
        run_frame(8'h07, 0);
        run_frame(8'h00, 0);
        run_frame(8'($urandom), 1);
        run_frame(8'($urandom), 2);
        run_frame(8'($urandom) & 8'hF7, 3);
        run_frame(8'($urandom), 0);
        for (int k = 0; k < 3; k++) run_frame(8'($urandom), k == 1 ? 1 : 0);
`ifdef PS2_TX_TIMEOUT_EN
        run_frame(8'($urandom), 4);
        run_frame(8'($urandom), 0);
`endif
        chk("done_busy_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global time limit reached");
    end

endmodule
